decode_issue_queue: RTL and testbench

DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

---
 rtl/ariane_pkg.sv | 12 +
 rtl/decode_issue_queue_if.sv | 32 +++
 rtl/decode_issue_queue.sv | 110 +++++++++++
 tb/tb_decode_issue_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Minimal ariane_pkg providing the decoded-instruction record carried by the
// decode/issue queue.
package ariane_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [4:0]  rd;
    logic [31:0] result;
  } scoreboard_entry_t;

endpackage

// File: rtl/decode_issue_queue_if.sv
// Decoder-side and issue-side handshake bundle for decode_issue_queue.
// Signal names keep the queue's point of view (_i into the queue, _o out of it).
interface decode_issue_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                          flush_i;
  ariane_pkg::scoreboard_entry_t decoded_entry_i;
  logic                          decoded_entry_valid_i;
  logic                          is_ctrl_flow_i;
  logic                          decoded_instr_ack_o;
  ariane_pkg::scoreboard_entry_t issue_entry_o;
  logic                          issue_entry_valid_o;
  logic                          is_ctrl_flow_o;
  logic                          issue_instr_ack_i;
  logic [CW-1:0]                 occupancy_o;
  logic [CW-1:0]                 ctrl_pending_o;

  modport master (
    output flush_i, decoded_entry_i, decoded_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
    input  decoded_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
           occupancy_o, ctrl_pending_o
  );

  modport slave (
    input  flush_i, decoded_entry_i, decoded_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
    output decoded_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
           occupancy_o, ctrl_pending_o
  );

endinterface

// File: rtl/decode_issue_queue.sv
// Decode-to-issue instruction queue: circular FIFO between decoder and issue stage
// that also caps how many control-flow instructions may be queued at once.
module decode_issue_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_CTRL = 1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  decode_issue_queue_if.slave q
);

  localparam int unsigned   PW         = $clog2(DEPTH);
  localparam int unsigned   CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] CTRL_LIMIT = CW'(MAX_CTRL);

  ariane_pkg::scoreboard_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] ctrl_q, ctrl_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    ctrl_cnt_q, ctrl_cnt_d;

  logic ack_s;
  logic push_s;
  logic pop_s;
  logic ctrl_push_s;
  logic ctrl_pop_s;

  // Acceptance looks only at registered occupancy; a same-cycle pop never frees a slot early
  always_comb begin
    ack_s = 1'b0;
    if (!q.flush_i && (cnt_q < FULL_CNT) &&
        !(q.is_ctrl_flow_i && (cnt_q != FULL_CNT + CW'(1)) && (ctrl_cnt_q == CTRL_LIMIT))) begin
      ack_s = 1'b1;
    end else begin
      ack_s = 1'b0;
    end
    push_s      = q.decoded_entry_valid_i & ack_s;
    pop_s       = (cnt_q != {CW{1'b0}}) & q.issue_instr_ack_i;
    ctrl_push_s = push_s & q.is_ctrl_flow_i;
    ctrl_pop_s  = pop_s & ctrl_q[rptr_q];
  end

  // Next-state for storage, pointers and counters; flush overrides push and pop
  always_comb begin
    mem_d      = mem_q;
    ctrl_d     = ctrl_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    ctrl_cnt_d = ctrl_cnt_q;
    if (q.flush_i) begin
      rptr_d     = {PW{1'b0}};
      wptr_d     = {PW{1'b0}};
      cnt_d      = {CW{1'b0}};
      ctrl_cnt_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wptr_q]  = q.decoded_entry_i;
        ctrl_d[wptr_q] = q.is_ctrl_flow_i;
        wptr_d         = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      case ({ctrl_push_s, ctrl_pop_s})
        2'b10:   ctrl_cnt_d = ctrl_cnt_q + CW'(1);
        2'b01:   ctrl_cnt_d = ctrl_cnt_q - CW'(1);
        default: ctrl_cnt_d = ctrl_cnt_q;
      endcase
    end
  end

  // State registers; reset wipes slots too so the head reads as zero while held in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q      <= '0;
      ctrl_q     <= {DEPTH{1'b0}};
      rptr_q     <= {PW{1'b0}};
      wptr_q     <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      ctrl_cnt_q <= {CW{1'b0}};
    end else begin
      mem_q      <= mem_d;
      ctrl_q     <= ctrl_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
    end
  end

  assign q.decoded_instr_ack_o = ack_s;
  assign q.issue_entry_o       = mem_q[rptr_q];
  assign q.is_ctrl_flow_o      = ctrl_q[rptr_q];
  assign q.issue_entry_valid_o = (cnt_q != {CW{1'b0}});
  assign q.occupancy_o         = cnt_q;
  assign q.ctrl_pending_o      = ctrl_cnt_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_decode_issue_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_CTRL = 1;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  decode_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  decode_issue_queue #(.DEPTH(DEPTH), .MAX_CTRL(MAX_CTRL)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .q     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic        c;
    logic        a;
    logic        f;
    logic [7:0]  tag;
    logic        e_ack;
    logic        e_val;
    logic        e_cf;
    logic [7:0]  e_tag;
    logic [2:0]  e_occ;
    logic [2:0]  e_ctl;
  } vec_t;

  typedef struct packed {
    logic [31:0] tag;
    logic        c;
  } item_t;

  item_t mq[$];

  function automatic ariane_pkg::scoreboard_entry_t mk(input logic [31:0] tag);
    ariane_pkg::scoreboard_entry_t e;
    e.pc     = tag;
    e.fu     = tag[3:0] ^ 4'h5;
    e.rd     = tag[8:4];
    e.result = ~tag;
    return e;
  endfunction

  function automatic int mctrl();
    int n = 0;
    foreach (mq[i]) if (mq[i].c) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic a, input logic f,
                       input logic [31:0] tag);
    bus.decoded_entry_valid_i = v;
    bus.is_ctrl_flow_i        = c;
    bus.issue_instr_ack_i     = a;
    bus.flush_i               = f;
    bus.decoded_entry_i       = mk(tag);
  endtask

  task automatic expect_out(input string nm, input logic ack, input logic val, input logic cf,
                            input logic [31:0] tag, input int occ, input int ctl);
    chk({nm, ".ack"},   128'(bus.decoded_instr_ack_o), 128'(ack));
    chk({nm, ".valid"}, 128'(bus.issue_entry_valid_o), 128'(val));
    chk({nm, ".occ"},   128'(bus.occupancy_o),         128'(occ));
    chk({nm, ".ctrl"},  128'(bus.ctrl_pending_o),      128'(ctl));
    if (val) begin
      chk({nm, ".entry"}, 128'(bus.issue_entry_o),  128'(mk(tag)));
      chk({nm, ".cf"},    128'(bus.is_ctrl_flow_o), 128'(cf));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle against the reference model: expected outputs come from the model's contents.
  task automatic mcycle(input logic v, input logic c, input logic a, input logic f,
                        input logic [31:0] tag, input string nm);
    logic eack;
    item_t it;
    drive(v, c, a, f, tag);
    @(negedge clk);
    eack = !f && (mq.size() < DEPTH) && !(c && (mctrl() == MAX_CTRL));
    if (mq.size() != 0) it = mq[0];
    else it = '0;
    expect_out(nm, eack, mq.size() != 0, it.c, it.tag, mq.size(), mctrl());
    tick();
    if (f) begin
      mq.delete();
    end else begin
      if (a && mq.size() != 0) void'(mq.pop_front());
      if (v && eack) mq.push_back(item_t'{tag: tag, c: c});
    end
  endtask

  vec_t vt[15];

  initial begin
    vt = '{
      '{1'b1,1'b0,1'b1,1'b0,8'h0A, 1'b1,1'b0,1'b0,8'h00,3'd0,3'd0},
      '{1'b1,1'b0,1'b0,1'b0,8'h0B, 1'b1,1'b1,1'b0,8'h0A,3'd1,3'd0},
      '{1'b1,1'b0,1'b0,1'b0,8'h0C, 1'b1,1'b1,1'b0,8'h0A,3'd2,3'd0},
      '{1'b1,1'b0,1'b0,1'b0,8'h0D, 1'b1,1'b1,1'b0,8'h0A,3'd3,3'd0},
      '{1'b1,1'b0,1'b0,1'b0,8'h0E, 1'b0,1'b1,1'b0,8'h0A,3'd4,3'd0},
      '{1'b1,1'b0,1'b1,1'b0,8'h0E, 1'b0,1'b1,1'b0,8'h0A,3'd4,3'd0},
      '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b1,1'b0,8'h0B,3'd3,3'd0},
      '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b1,1'b0,8'h0C,3'd2,3'd0},
      '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b1,1'b0,8'h0D,3'd1,3'd0},
      '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,8'h00,3'd0,3'd0},
      '{1'b1,1'b1,1'b0,1'b0,8'h10, 1'b1,1'b0,1'b0,8'h00,3'd0,3'd0},
      '{1'b1,1'b0,1'b0,1'b0,8'h11, 1'b1,1'b1,1'b1,8'h10,3'd1,3'd1},
      '{1'b1,1'b0,1'b0,1'b0,8'h12, 1'b1,1'b1,1'b1,8'h10,3'd2,3'd1},
      '{1'b1,1'b0,1'b1,1'b1,8'h13, 1'b0,1'b1,1'b1,8'h10,3'd3,3'd1},
      '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,8'h00,3'd0,3'd0}
    };

    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", 128'(bus.issue_entry_valid_o), 128'(0));
    chk("rst.cf",    128'(bus.is_ctrl_flow_o),      128'(0));
    chk("rst.occ",   128'(bus.occupancy_o),         128'(0));
    chk("rst.ctrl",  128'(bus.ctrl_pending_o),      128'(0));
    chk("rst.entry", 128'(bus.issue_entry_o),       128'(0));
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst.ack", 128'(bus.decoded_instr_ack_o), 128'(1));
    tick();

    // Fill/drain, full-with-pop, latency and flush-with-push vectors
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].v, vt[i].c, vt[i].a, vt[i].f, {24'h0, vt[i].tag});
      @(negedge clk);
      expect_out($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_val, vt[i].e_cf,
                 {24'h0, vt[i].e_tag}, int'(vt[i].e_occ), int'(vt[i].e_ctl));
      tick();
    end

    // Control-flow limit: a second branch waits until the first pops, a non-branch does not
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h21); @(negedge clk);
    expect_out("ctl.j1", 1'b1, 1'b0, 1'b0, 32'h0, 0, 0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h22); @(negedge clk);
    expect_out("ctl.j2a", 1'b0, 1'b1, 1'b1, 32'h21, 1, 1); tick();
    @(negedge clk);
    expect_out("ctl.j2b", 1'b0, 1'b1, 1'b1, 32'h21, 1, 1); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h23); @(negedge clk);
    expect_out("ctl.nb", 1'b1, 1'b1, 1'b1, 32'h21, 1, 1); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h22); @(negedge clk);
    expect_out("ctl.j2pop", 1'b0, 1'b1, 1'b1, 32'h21, 2, 1); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h22); @(negedge clk);
    expect_out("ctl.j2ok", 1'b1, 1'b1, 1'b0, 32'h23, 1, 0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
    expect_out("ctl.d0", 1'b1, 1'b1, 1'b0, 32'h23, 2, 1); tick();
    @(negedge clk);
    expect_out("ctl.d1", 1'b1, 1'b1, 1'b1, 32'h22, 1, 1); tick();
    @(negedge clk);
    expect_out("ctl.d2", 1'b1, 1'b0, 1'b0, 32'h0, 0, 0); tick();

    // Wrap-around: keep two entries queued while ten push/pop pairs walk the pointers
    mq.delete();
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, "wrap.fill0");
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h101, "wrap.fill1");
    for (int i = 0; i < 10; i++)
      mcycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h102 + 32'(i), $sformatf("wrap.pair%0d", i));

    // Asynchronous reset in the middle of a cycle with two entries queued
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("arst.pre_occ", 128'(bus.occupancy_o), 128'(2));
    rst_ni = 1'b0;
    #1;
    chk("arst.valid", 128'(bus.issue_entry_valid_o), 128'(0));
    chk("arst.occ",   128'(bus.occupancy_o),         128'(0));
    chk("arst.entry", 128'(bus.issue_entry_o),       128'(0));
    mq.delete();
    tick();
    rst_ni = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      mcycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
             $urandom, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
